// File: rtl/scan_pkg.sv
// Shared defaults for the time-multiplexed display channel selector.
// Index widths are derived locally from the channel count by each user.
package scan_pkg;

  localparam int SCAN_N_CH_DEF     = 8;
  localparam int SCAN_W_DEF        = 4;
  localparam int SCAN_TICK_DIV_DEF = 100000;

endpackage : scan_pkg

// File: rtl/next_en_idx.sv
// Combinational round-robin finder: the first enabled channel after cur,
// wrapping modulo N_CH, with cur itself as the last candidate.
module next_en_idx #(
  parameter  int N_CH = 8,
  localparam int IDXW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] ch_en,
  input  logic [IDXW-1:0] cur,
  output logic [IDXW-1:0] nxt,
  output logic            any
);

  int              cand;
  logic [IDXW-1:0] cand_idx;

  // Walk the candidates farthest-first so the nearest enabled one wins.
  always_comb begin
    nxt      = cur;
    any      = |ch_en;
    cand     = 0;
    cand_idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand     = (int'(cur) + k) % N_CH;
      cand_idx = IDXW'(cand);
      if (ch_en[cand_idx]) nxt = cand_idx;
    end
  end

endmodule : next_en_idx

// File: rtl/scan_mux.sv
// N-channel round-robin display selector: prescaler, pointer and a registered
// output stage presenting the selected value, its index and an active-low strobe.
module scan_mux
  import scan_pkg::*;
#(
  parameter  int N_CH     = SCAN_N_CH_DEF,
  parameter  int W        = SCAN_W_DEF,
  parameter  int TICK_DIV = SCAN_TICK_DIV_DEF,
  localparam int IDXW     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0][W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_en,
  input  logic                   hold,
  input  logic                   manual,
  input  logic [IDXW-1:0]        manual_sel,
  output logic [W-1:0]           sel_data,
  output logic [IDXW-1:0]        sel_idx,
  output logic [N_CH-1:0]        sel_onehot_n,
  output logic                   valid,
  output logic                   tick
);

  localparam int             PCW     = $clog2(TICK_DIV);
  localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_DIV - 1);

  logic [PCW-1:0]  pcnt;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] nxt;
  logic            any;

  logic            in_range;
  logic            valid_d;
  logic [W-1:0]    data_d;
  logic [N_CH-1:0] onehot_d;

  assign tick = (pcnt == PC_LAST) && !hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!hold) begin
      pcnt <= (pcnt == PC_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  next_en_idx #(.N_CH(N_CH)) u_next (
    .ch_en (ch_en),
    .cur   (ptr),
    .nxt   (nxt),
    .any   (any)
  );

  // Manual mode overrides scanning every cycle; an empty enable mask parks ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (manual) begin
      ptr <= manual_sel;
    end else if (tick && any) begin
      ptr <= nxt;
    end
  end

  // NOTE: every combinational output is given a default first so no latch
  // can be inferred on any path.
  always_comb begin
    in_range = (int'(ptr) < N_CH);
    valid_d  = in_range && ch_en[ptr];
    data_d   = '0;
    onehot_d = '1;
    if (valid_d) begin
      data_d   = ch_data[ptr];
      onehot_d = ~(N_CH'(1) << ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_data     <= '0;
      sel_idx      <= '0;
      sel_onehot_n <= '1;
      valid        <= 1'b0;
    end else begin
      sel_data     <= data_d;
      sel_idx      <= ptr;
      sel_onehot_n <= onehot_d;
      valid        <= valid_d;
    end
  end

endmodule : scan_mux

// File: tb/tb_scan_mux.sv
// Randomised and directed bench for scan_mux: a channel-level reference model
// queues expected outputs; a separate monitor compares them every cycle.
module tb_scan_mux;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int TD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][W-1:0] ch_data;
  logic [N-1:0]      ch_en;
  logic              hold;
  logic              manual;
  logic [2:0]        manual_sel;
  logic [W-1:0]      sel_data;
  logic [2:0]        sel_idx;
  logic [N-1:0]      sel_onehot_n;
  logic              valid;
  logic              tick;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   idx;
    logic [N-1:0] onehot;
    logic         valid;
    logic         tick;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: dwell counter and current channel.
  int m_pcnt = 0;
  int m_ptr  = 0;
  logic [N-1:0][W-1:0] nxt_data;
  logic [N-1:0]        cur_en;
  bit                  cur_man;

  scan_mux #(.N_CH(N), .W(W), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_data      (ch_data),
    .ch_en        (ch_en),
    .hold         (hold),
    .manual       (manual),
    .manual_sel   (manual_sel),
    .sel_data     (sel_data),
    .sel_idx      (sel_idx),
    .sel_onehot_n (sel_onehot_n),
    .valid        (valid),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic step(input bit r, input bit h, input bit m, input int ms, input logic [N-1:0] en);
    exp_t e;
    bit   t;
    bit   found;
    int   c;
    @(negedge clk);
    rst        = r;
    hold       = h;
    manual     = m;
    manual_sel = ms[2:0];
    ch_en      = en;
    ch_data    = nxt_data;
    if (r) begin
      e.data   = '0;
      e.idx    = '0;
      e.onehot = '1;
      e.valid  = 1'b0;
      m_pcnt   = 0;
      m_ptr    = 0;
    end else begin
      e.valid  = en[m_ptr];
      e.idx    = m_ptr[2:0];
      e.data   = e.valid ? nxt_data[m_ptr] : '0;
      e.onehot = e.valid ? ~(8'(1) << m_ptr) : 8'hFF;
      t = (m_pcnt == TD - 1) && !h;
      if (!h) m_pcnt = (m_pcnt + 1) % TD;
      if (m) begin
        m_ptr = ms;
      end else if (t) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && en[c]) begin
            m_ptr = c;
            found = 1;
          end
        end
      end
    end
    e.tick = (m_pcnt == TD - 1) && !h;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit h, input bit m, input int ms, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) step(1'b0, h, m, ms, en);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid",  32'(valid),        32'(e.valid));
        check("idx",    32'(sel_idx),      32'(e.idx));
        check("data",   32'(sel_data),     32'(e.data));
        check("onehot", 32'(sel_onehot_n), 32'(e.onehot));
        check("tick",   32'(tick),         32'(e.tick));
      end
    end
  end

  initial begin : driver
    logic [N-1:0] en;
    bit r, h;
    int ms;
    for (int i = 0; i < N; i++) nxt_data[i] = W'(i + 1);

    step(1'b1, 1'b0, 1'b0, 0, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 0, 8'hFF);
    run(40, 1'b0, 1'b0, 0, 8'hFF);
    run(30, 1'b0, 1'b0, 0, 8'b1000_0101);
    run(16, 1'b0, 1'b0, 0, 8'b0001_0000);
    run(12, 1'b0, 1'b0, 0, 8'h00);
    run(2,  1'b0, 1'b0, 0, 8'hFF);
    run(6,  1'b1, 1'b0, 0, 8'hFF);
    run(12, 1'b0, 1'b0, 0, 8'hFF);
    run(12, 1'b0, 1'b1, 5, 8'hFF);
    run(10, 1'b0, 1'b0, 0, 8'hFF);

    run(1, 1'b0, 1'b0, 0, 8'hFF);
    en = 8'hFF & ~(8'(1) << m_ptr);
    run(3, 1'b0, 1'b0, 0, en);
    run(10, 1'b0, 1'b0, 0, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 0, 8'hFF);
    run(12, 1'b0, 1'b0, 0, 8'hFF);

    en      = 8'hFF;
    cur_man = 0;
    ms      = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) en = 8'($urandom());
      if ($urandom_range(0, 3) == 0) nxt_data[$urandom_range(0, N - 1)] = W'($urandom());
      if ($urandom_range(0, 24) == 0) cur_man = !cur_man;
      if ($urandom_range(0, 5) == 0) ms = int'($urandom_range(0, N - 1));
      h = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 59) == 0);
      step(r, h, cur_man, ms, en);
    end

    @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_scan_mux
